uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.
- A grant is held for a whole packet, ending on the byte flagged last. A grant is also released when MAX_BURST bytes have been sent or the owner stalls for STALL_TIMEOUT cycles.
- Sits between client logic (command responders, debug echo) and the UART transmit datapath.
- Drives the transmitter with a one-cycle start pulse, then waits for its done pulse.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream requesters.
// Latency: grant one cycle after a request in IDLE, tx_start one cycle after the byte is accepted.
// Backpressure: req_ready follows the owner's req_valid only in SEND; everyone else waits, no preemption.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_byte,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  input  logic                   tx_done,
  output logic                   busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t                     state, state_nxt;
  logic [IDXW-1:0]            owner;
  logic [IDXW-1:0]            rr_ptr;
  logic [IDXW-1:0]            sel_idx;
  logic [IDXW-1:0]            cand;
  logic                       sel_vld;
  logic [7:0]                 byte_cnt;
  logic [7:0]                 stall_cnt;
  logic                       end_flag;
  logic                       accept;
  logic                       release_grant;
  logic                       take_grant;
  logic [NUM_REQ-1:0][7:0]    byte_arr;

  assign byte_arr = req_byte;
  assign busy     = (state != IDLE);

  // Pick the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDXW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!sel_vld && req_valid[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Next-state and control strobes; req_ready is only ever the owner's valid while in SEND.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    accept        = 1'b0;
    release_grant = 1'b0;
    take_grant    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          take_grant = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        req_ready[owner] = req_valid[owner];
        if (req_valid[owner]) begin
          accept    = 1'b1;
          state_nxt = WAIT_DONE;
        end else if (stall_cnt == 8'(STALL_TIMEOUT - 1)) begin
          release_grant = 1'b1;
          state_nxt     = IDLE;
        end
      end
      WAIT_DONE: begin
        // A done pulse coincident with our own start pulse cannot belong to this frame.
        if (tx_done && !tx_start) begin
          if (end_flag || (byte_cnt == 8'(MAX_BURST))) begin
            release_grant = 1'b1;
            state_nxt     = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be accepted on a cycle that reset is about to wipe out.
    if (!reset_n) begin
      req_ready = '0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant, transmit byte, counters and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      end_flag  <= 1'b0;
    end else begin
      tx_start <= accept;
      if (take_grant) begin
        grant     <= NUM_REQ'(1) << sel_idx;
        owner     <= sel_idx;
        byte_cnt  <= '0;
        stall_cnt <= '0;
      end
      if (accept) begin
        tx_byte   <= byte_arr[owner];
        byte_cnt  <= byte_cnt + 8'd1;
        end_flag  <= req_last[owner];
        stall_cnt <= '0;
      end else if (state == SEND) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      if (release_grant) begin
        grant  <= '0;
        rr_ptr <= (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a transmitter model and a scoreboard monitor.
// Expected byte/owner order comes from a packet-level round-robin model.
// Directed cases cover timeout, spurious done and reset; random rounds follow.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int ST = 12;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_byte  = '0;
  logic [N-1:0]     req_last  = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             tx_done;
  logic             busy;
  logic             xd = 1'b0;
  logic             sd = 1'b0;

  assign tx_done = xd | sd;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .STALL_TIMEOUT(ST)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_byte(req_byte),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_done(tx_done), .busy(busy)
  );

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  src_q [N][$];
  logic [8:0]  mq    [N][$];
  logic [10:0] exp_q [$];
  int          m_rr    = 0;
  int          lat_fix = 3;
  bit          mon_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic expect_byte(input int i, input logic [7:0] b);
    exp_q.push_back({3'(i), b});
  endtask

  task automatic src_push(input int i, input logic [7:0] b, input logic last);
    src_q[i].push_back({last, b});
  endtask

  task automatic add_pkt(input int i, input int len, input logic [7:0] base);
    logic [7:0] b;
    logic       l;
    for (int k = 0; k < len; k++) begin
      b = base + 8'(k);
      l = (k == len - 1);
      src_push(i, b, l);
      mq[i].push_back({l, b});
    end
  endtask

  // Packet-level model: the next owner is the first requester with pending data from
  // m_rr upward; it sends until its last byte or MB bytes, then the pointer moves past it.
  task automatic model_run();
    int         o;
    int         c;
    int         cnt;
    logic [8:0] e;
    while (1) begin
      o = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (o < 0 && mq[c].size() > 0) o = c;
      end
      if (o < 0) break;
      cnt = 0;
      while (mq[o].size() > 0) begin
        e = mq[o].pop_front();
        expect_byte(o, e[7:0]);
        cnt++;
        if (e[8] || cnt == MB) break;
      end
      m_rr = (o + 1) % N;
    end
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clock);
      t++;
      if (tx_done === 1'b1) seen++;
    end
    if (seen < n) timeout(name);
  endtask

  task automatic wait_txstart(input int budget, input string name);
    int t = 0;
    @(negedge clock);
    while (tx_start !== 1'b1 && t < budget) begin
      @(negedge clock);
      t++;
    end
    if (t >= budget) timeout(name);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < budget) begin
      @(negedge clock);
      t++;
    end
    if (t >= budget) timeout("drain");
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    m_rr = 0;
  endtask

  // Requester driver: pops a byte the edge after it was accepted, then presents the next head.
  initial begin
    logic [N-1:0] acc;
    logic [8:0]   dummy;
    forever begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) dummy = src_q[i].pop_front();
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_byte[i*8 +: 8]  = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter model: answers each start pulse with a done pulse some cycles later.
  initial begin
    int lat;
    forever begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
        repeat (lat) @(posedge clock);
        #1 xd = 1'b1;
        @(posedge clock);
        #1 xd = 1'b0;
      end
    end
  end

  // Monitor: every start pulse must match the scoreboard head; grant/ready invariants every cycle.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        check("ready_within_grant", 32'(req_ready & ~grant), 32'h0);
        check("grant_onehot0", 32'($onehot0(grant)), 32'h1);
        check("busy_vs_grant", 32'(busy), 32'(|grant));
        if (tx_start === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_tx_start: byte %0h grant %0h at %0t", tx_byte, grant, $time);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(e[7:0]));
            check("tx_owner", 32'(grant), 32'(1) << e[10:8]);
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    int np;
    int len;

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    mon_on = 1'b1;

    // Single three-byte packet from requester 1.
    lat_fix = 10;
    add_pkt(1, 3, 8'h41);
    model_run();
    wait_dones(3, 200, "single_dones");
    check("single_grant_held", 32'(grant), 32'h2);
    @(posedge clock);
    @(negedge clock);
    check("single_release_grant", 32'(grant), 32'h0);
    check("single_release_busy", 32'(busy), 32'h0);
    wait_drain(200);

    // Contention from reset: 0,2,3 then 0 again.
    do_reset();
    lat_fix = 0;
    add_pkt(0, 1, 8'hA0);
    add_pkt(2, 1, 8'hA2);
    add_pkt(3, 1, 8'hA3);
    add_pkt(0, 1, 8'hB0);
    model_run();
    wait_drain(400);

    // Burst limit: six-byte packet on 2 is cut after MB bytes for 3's packet.
    add_pkt(2, 6, 8'h20);
    add_pkt(3, 2, 8'h30);
    model_run();
    wait_drain(600);

    // Stall timeout: requester 1 goes quiet mid-packet while 3 waits.
    do_reset();
    lat_fix = 3;
    src_push(1, 8'h50, 1'b0);
    src_push(1, 8'h51, 1'b0);
    src_push(3, 8'h70, 1'b1);
    expect_byte(1, 8'h50);
    expect_byte(1, 8'h51);
    expect_byte(3, 8'h70);
    wait_dones(2, 200, "stall_dones");
    @(posedge clock);
    repeat (ST - 1) @(posedge clock);
    @(negedge clock);
    check("stall_grant_before_timeout", 32'(grant), 32'h2);
    @(posedge clock);
    @(negedge clock);
    check("stall_grant_released", 32'(grant), 32'h0);
    check("stall_busy_released", 32'(busy), 32'h0);
    @(posedge clock);
    @(negedge clock);
    check("stall_next_owner", 32'(grant), 32'h8);
    wait_drain(200);
    src_push(1, 8'h52, 1'b0);
    src_push(1, 8'h53, 1'b1);
    expect_byte(1, 8'h52);
    expect_byte(1, 8'h53);
    wait_drain(200);
    m_rr = 2;

    // Spurious done pulses in IDLE, in SEND, and coincident with tx_start.
    @(posedge clock);
    #1 sd = 1'b1;
    @(posedge clock);
    #1 sd = 1'b0;
    @(negedge clock);
    check("spur_idle_busy", 32'(busy), 32'h0);
    check("spur_idle_start", 32'(tx_start), 32'h0);
    @(negedge clock);
    check("spur_idle_grant", 32'(grant), 32'h0);
    src_push(1, 8'h60, 1'b0);
    expect_byte(1, 8'h60);
    wait_dones(1, 100, "spur_send_done");
    @(posedge clock);
    #1 sd = 1'b1;
    @(posedge clock);
    #1 sd = 1'b0;
    @(negedge clock);
    check("spur_send_start", 32'(tx_start), 32'h0);
    check("spur_send_grant", 32'(grant), 32'h2);
    @(negedge clock);
    check("spur_send_start2", 32'(tx_start), 32'h0);
    src_push(1, 8'h61, 1'b1);
    expect_byte(1, 8'h61);
    wait_txstart(50, "spur_txstart");
    sd = 1'b1;
    @(posedge clock);
    #1 sd = 1'b0;
    @(negedge clock);
    check("same_cycle_done_grant", 32'(grant), 32'h2);
    check("same_cycle_done_busy", 32'(busy), 32'h1);
    wait_drain(200);
    m_rr = 2;

    // Reset while waiting for done; the stale done must be ignored, arbitration restarts at 0.
    add_pkt(2, 1, 8'h80);
    model_run();
    wait_drain(200);
    lat_fix = 10;
    src_push(2, 8'h81, 1'b1);
    expect_byte(2, 8'h81);
    wait_txstart(50, "rst_mid_txstart");
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_grant", 32'(grant), 32'h0);
    check("rst_mid_tx_start", 32'(tx_start), 32'h0);
    check("rst_mid_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_req_ready", 32'(req_ready), 32'h0);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clock);
      if (busy !== 1'b0 || grant !== '0) ok = 1'b0;
    end
    check("rst_mid_stale_done", 32'(ok), 32'h1);
    m_rr = 0;
    lat_fix = 0;
    add_pkt(3, 1, 8'h90);
    add_pkt(0, 1, 8'hA0);
    model_run();
    wait_drain(200);

    // Random rounds.
    repeat (8) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          np = int'($urandom_range(1, 2));
          for (int p = 0; p < np; p++) begin
            len = int'($urandom_range(1, 6));
            add_pkt(i, len, 8'($urandom));
          end
        end
      end
      model_run();
      wait_drain(3000);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
